// File: rtl/piso_frame_tx.sv
// Parallel-in/serial-out asynchronous frame transmitter: start, DATA_W data bits, optional parity, 1-2 stops.
// Optional parity bit is compiled in with macro PISO_FRAME_PARITY_EN.
module piso_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int LSB_FIRST  = 1,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] TX_data,
    input  logic              TX_valid,
    output logic              TX_ready,
    input  logic              shift,
    output logic              OUT,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             PAR_SENSE = (PARITY_ODD != 0);

    if (DATA_W < 5 || DATA_W > 16 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("piso_frame_tx: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PISO_FRAME_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              out_q, out_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef PISO_FRAME_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // The bit presented on the line sits at the output end of the register.
    function automatic logic end_bit(input logic [DATA_W-1:0] s);
        return (LSB_FIRST != 0) ? s[0] : s[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] s);
        return (LSB_FIRST != 0) ? {1'b0, s[DATA_W-1:1]} : {s[DATA_W-2:0], 1'b0};
    endfunction

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;
`ifdef PISO_FRAME_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (TX_valid && ready_q) begin
                    shreg_d    = TX_data;
                    cnt_d      = '0;
                    stop_cnt_d = 1'b0;
`ifdef PISO_FRAME_PARITY_EN
                    parity_d   = (^TX_data) ^ PAR_SENSE;
`endif
                    state_d    = START;
                end
            end
            START: begin
                if (shift) state_d = DATA;
            end
            DATA: begin
                if (shift) begin
                    shreg_d = advance(shreg_q);
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
`ifdef PISO_FRAME_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef PISO_FRAME_PARITY_EN
            PARITY: begin
                if (shift) state_d = STOP;
            end
`endif
            STOP: begin
                if (shift) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered with it.
        out_d = 1'b1;
        case (state_d)
            START:   out_d = 1'b0;
            DATA:    out_d = end_bit(shreg_d);
`ifdef PISO_FRAME_PARITY_EN
            PARITY:  out_d = parity_d;
`endif
            default: out_d = 1'b1;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            stop_cnt_q <= 1'b0;
            out_q      <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PISO_FRAME_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            stop_cnt_q <= stop_cnt_d;
            out_q      <= out_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef PISO_FRAME_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign OUT      = out_q;
    assign TX_ready = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Self-checking bench for piso_frame_tx: four differently parameterised instances against a frame-level model.
module tb_piso_frame_tx;

`ifdef PISO_FRAME_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid;
    logic        shift;
    logic [15:0] tx_data;
    logic [3:0]  en;
    logic [3:0]  out_v, busy_v, done_v, rdy_v;

    int checks = 0;
    int errors = 0;

    logic [31:0] ebits [4];
    int          elen  [4];
    int          epos  [4];
    int          edone [4];
    bit          act   [4];
    int          dcnt  [4];

    always #5 clk = ~clk;

    piso_frame_tx #(.DATA_W(8), .LSB_FIRST(1), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .CLK(clk), .RST(rst), .TX_data(tx_data[7:0]), .TX_valid(tx_valid & en[0]),
        .TX_ready(rdy_v[0]), .shift(shift), .OUT(out_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    piso_frame_tx #(.DATA_W(8), .LSB_FIRST(0), .STOP_BITS(2), .PARITY_ODD(0)) u1 (
        .CLK(clk), .RST(rst), .TX_data(tx_data[7:0]), .TX_valid(tx_valid & en[1]),
        .TX_ready(rdy_v[1]), .shift(shift), .OUT(out_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    piso_frame_tx #(.DATA_W(5), .LSB_FIRST(1), .STOP_BITS(1), .PARITY_ODD(1)) u2 (
        .CLK(clk), .RST(rst), .TX_data(tx_data[4:0]), .TX_valid(tx_valid & en[2]),
        .TX_ready(rdy_v[2]), .shift(shift), .OUT(out_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    piso_frame_tx #(.DATA_W(8), .LSB_FIRST(0), .STOP_BITS(2), .PARITY_ODD(1)) u3 (
        .CLK(clk), .RST(rst), .TX_data(tx_data[7:0]), .TX_valid(tx_valid & en[3]),
        .TX_ready(rdy_v[3]), .shift(shift), .OUT(out_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    always @(posedge clk)
        for (int k = 0; k < 4; k++)
            if (done_v[k] === 1'b1) dcnt[k] <= dcnt[k] + 1;

    // Instance configuration table
    function automatic int pw(input int k);    return (k == 2) ? 5 : 8;          endfunction
    function automatic bit plsb(input int k);  return (k == 0) || (k == 2);       endfunction
    function automatic int pstop(input int k); return (k == 1 || k == 3) ? 2 : 1; endfunction
    function automatic bit podd(input int k);  return (k >= 2);                   endfunction

    function automatic int frame_len(input int k);
        return 1 + pw(k) + PAR + pstop(k);
    endfunction

    // Line level seen after each strobe, index 0 being the start bit.
    function automatic logic [31:0] frame_bits(input int k, input logic [15:0] d);
        logic [31:0] f = '0;
        int n = 1;
        bit p = podd(k);
        for (int i = 0; i < pw(k); i++) begin
            f[n] = plsb(k) ? d[i] : d[pw(k)-1-i];
            p ^= d[i];
            n++;
        end
        if (PAR == 1) begin
            f[n] = p;
            n++;
        end
        for (int j = 0; j < pstop(k); j++) begin
            f[n] = 1'b1;
            n++;
        end
        return f;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[u%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit any_act();
        return act[0] | act[1] | act[2] | act[3];
    endfunction

    task automatic arm(input int k, input logic [15:0] d);
        ebits[k] = frame_bits(k, d);
        elen[k]  = frame_len(k);
        epos[k]  = 0;
        act[k]   = 1'b1;
    endtask

    task automatic accept(input logic [3:0] m, input logic [15:0] d, input bit hold);
        en = m;
        tx_data = d;
        tx_valid = 1'b1;
        for (int k = 0; k < 4; k++)
            if (m[k]) chk("ready_idle", k, 32'(rdy_v[k]), 32'd1);
        tick();
        if (!hold) tx_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                arm(k, d);
                chk("start_out", k, 32'(out_v[k]), 32'd0);
                chk("start_busy", k, 32'(busy_v[k]), 32'd1);
                chk("start_ready", k, 32'(rdy_v[k]), 32'd0);
            end
        end
    endtask

    task automatic strobe(input int gap, input bit inject);
        logic        sv_valid;
        logic [15:0] sv_data;
        for (int g = 0; g < gap; g++) begin
            sv_valid = tx_valid;
            sv_data  = tx_data;
            if (inject && g == 0) begin
                tx_valid = 1'b1;
                tx_data  = 16'hFFFF;
            end
            tick();
            tx_valid = sv_valid;
            tx_data  = sv_data;
            for (int k = 0; k < 4; k++)
                if (act[k]) chk("hold_out", k, 32'(out_v[k]), 32'(ebits[k][epos[k]]));
        end
        shift = 1'b1;
        tick();
        shift = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (act[k]) begin
                epos[k]++;
                if (epos[k] < elen[k]) begin
                    chk("bit_out", k, 32'(out_v[k]), 32'(ebits[k][epos[k]]));
                    chk("bit_busy", k, 32'(busy_v[k]), 32'd1);
                    chk("bit_done", k, 32'(done_v[k]), 32'd0);
                end else begin
                    chk("end_done", k, 32'(done_v[k]), 32'd1);
                    chk("end_busy", k, 32'(busy_v[k]), 32'd0);
                    chk("end_ready", k, 32'(rdy_v[k]), 32'd1);
                    chk("end_out", k, 32'(out_v[k]), 32'd1);
                    act[k] = 1'b0;
                    edone[k]++;
                end
            end
        end
    endtask

    task automatic finish_frames(input int lo, input int hi, input int inject_at);
        int guard = 0;
        while (any_act() && guard < 64) begin
            strobe($urandom_range(hi, lo), guard == inject_at);
            guard++;
        end
        if (guard >= 64) begin
            chk("strobe_budget", 0, 32'd1, 32'd0);
            for (int k = 0; k < 4; k++) act[k] = 1'b0;
        end
    endtask

    task automatic after_frames(input logic [3:0] m);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                chk("done_one_cycle", k, 32'(done_v[k]), 32'd0);
                chk("done_count", k, 32'(dcnt[k]), 32'(edone[k]));
            end
        end
    endtask

    task automatic run(input logic [3:0] m, input logic [15:0] d, input int lo, input int hi,
                       input int inject_at);
        accept(m, d, 1'b0);
        finish_frames(lo, hi, inject_at);
        after_frames(m);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            act[k] = 1'b0;
            edone[k] = 0;
        end
        rst = 1'b1;
        shift = 1'b0;
        tx_valid = 1'b0;
        tx_data = '0;
        en = '0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Reset mid-idle with a word offered and a strobe present: reset wins
        rst = 1'b1;
        en = 4'hF;
        tx_valid = 1'b1;
        tx_data = 16'h00A5;
        tick();
        shift = 1'b1;
        tick();
        shift = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("rst_out", k, 32'(out_v[k]), 32'd1);
            chk("rst_ready", k, 32'(rdy_v[k]), 32'd1);
            chk("rst_busy", k, 32'(busy_v[k]), 32'd0);
            chk("rst_done", k, 32'(done_v[k]), 32'd0);
        end
        tx_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Directed frames: LSB-first A5, MSB-first 81 even/odd parity, 5-bit 13
        run(4'b0001, 16'h00A5, 15, 15, -1);
        run(4'b0010, 16'h0081, 3, 3, -1);
        run(4'b1000, 16'h0081, 2, 2, -1);
        run(4'b0100, 16'h0013, 2, 2, -1);

        // Reset during data bit 3, then a clean frame
        accept(4'b0001, 16'h005A, 1'b0);
        for (int s = 0; s < 4; s++) strobe(2, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        act[0] = 1'b0;
        chk("midrst_out", 0, 32'(out_v[0]), 32'd1);
        chk("midrst_ready", 0, 32'(rdy_v[0]), 32'd1);
        chk("midrst_busy", 0, 32'(busy_v[0]), 32'd0);
        chk("midrst_done", 0, 32'(done_v[0]), 32'd0);
        tick();
        chk("midrst_no_done", 0, 32'(dcnt[0]), 32'(edone[0]));
        run(4'b0001, 16'h003C, 1, 3, -1);

        // TX_valid pulse with FF while busy is ignored
        run(4'b0001, 16'h0042, 2, 2, 3);

        // Held TX_valid: second word accepted on the done cycle
        accept(4'b0001, 16'h0096, 1'b1);
        tx_data = 16'h0069;
        finish_frames(1, 3, -1);
        tick();
        tx_valid = 1'b0;
        chk("b2b_start_out", 0, 32'(out_v[0]), 32'd0);
        chk("b2b_start_busy", 0, 32'(busy_v[0]), 32'd1);
        chk("b2b_start_ready", 0, 32'(rdy_v[0]), 32'd0);
        arm(0, 16'h0069);
        finish_frames(1, 3, -1);
        after_frames(4'b0001);

        // Random words on every instance at once
        for (int r = 0; r < 8; r++)
            run(4'hF, 16'($urandom), 1, 4, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_frame_tx.md
# piso_frame_tx

Parametrised successor to the team's 8-bit parallel-in/serial-out shifter. It accepts a DATA_W-bit word over a valid/ready handshake and emits a complete asynchronous-serial frame on OUT: start bit, data in configurable bit order, optional parity, and 1 or 2 stop bits. Bits advance on an external baud strobe. It sits between the UART transmit holding logic and the TX pin driver.

## Interface
Parameters:
- DATA_W, 8: data bits per frame; legal range 5..16.
- LSB_FIRST, 1: 1 sends TX_data[0] first; 0 sends TX_data[DATA_W-1] first.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- PARITY_ODD, 0: parity sense when parity is compiled in; 0 is even, 1 is odd. Ignored otherwise.

Ports:
- CLK  input  1  sole clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- TX_data  input  DATA_W  word to transmit; sampled only at handshake.
- TX_valid  input  1  TX_data valid.
- TX_ready  output  1  block can accept a word (high only in IDLE).
- shift  input  1  baud strobe, one CLK wide; advances one bit per strobe.
- OUT  output  1  serial line; idles high.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame completion.

## Operation
- Reset values: OUT=1, TX_ready=1, busy=0, done=0, state=IDLE, shift register=0, counters=0.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: OUT=1, TX_ready=1. When TX_valid&&TX_ready, latch TX_data into the shift register, compute parity from TX_data, clear the bit counter, and go to START. While idle, shift is ignored.
- START: OUT=0. On shift, go to DATA.
- DATA: OUT = shreg[0] when LSB_FIRST=1, else shreg[DATA_W-1]. On each shift, shift the register toward the output end, filling with 0, and increment the bit counter. The counter is $clog2(DATA_W+1) bits wide. On the shift that ends bit DATA_W-1, go to PARITY if it is compiled in, else go to STOP.
- PARITY: OUT = parity bit. On shift, go to STOP.
- STOP: OUT=1 for STOP_BITS strobe intervals, counted by a stop counter. On the shift ending the last stop bit: go to IDLE, pulse done, and set TX_ready=1.
- TX_valid while busy is ignored. TX_data changes after acceptance do not affect the frame.
- RST has priority over every event. Reset mid-frame returns the block to IDLE with OUT=1 on the next edge, and done is not pulsed.
- A shift strobe in the same cycle as acceptance is ignored. The first strobe seen in START ends the start bit.

## Timing
- Acceptance edge is T. From T+1: busy=1, TX_ready=0, OUT=0 (start bit).
- Each bit is held from the edge after one strobe through the edge after the next strobe. OUT changes on the CLK edge at which shift is sampled high.
- Frame length is 1 + DATA_W + P + STOP_BITS strobes, where P is 1 with parity compiled in and 0 without.
- done is high for exactly the one cycle following the final strobe edge. In that same cycle busy=0 and TX_ready=1.
- Back-to-back: if TX_valid is held high, the next word is accepted on the edge at which done is high. The line therefore shows at least one CLK of idle-high between frames.
- All outputs are registered. There is no combinational path from any input to OUT, busy, or done. TX_ready is a registered state decode.

## Configuration
- Macro PISO_FRAME_PARITY_EN.
- Defined: the PARITY state exists, and one parity bit is sent after the data. Even parity is the XOR of the data bits; odd parity is its complement (PARITY_ODD=1).
- Undefined: no PARITY state and no parity logic. The frame is start + data + stops, and PARITY_ODD has no effect.

## Test plan
- Reset: assert RST for 3 cycles mid-idle -> OUT=1, TX_ready=1, busy=0, done=0.
- LSB-first default (DATA_W=8, STOP_BITS=1, no parity): send 8'hA5 with a strobe every 16 CLKs -> OUT sequence per strobe is 0,1,0,1,0,0,1,0,1,1. done pulses once, one cycle after the 10th strobe.
- MSB-first, STOP_BITS=2, PISO_FRAME_PARITY_EN defined, PARITY_ODD=0: send 8'h81 -> OUT is 0,1,0,0,0,0,0,0,1,0(parity),1,1. Repeat with PARITY_ODD=1 -> parity bit is 1.
- DATA_W=5: send 5'h13 LSB-first -> OUT is 0,1,1,0,0,1,1 and busy spans 7 strobes.
- Reset mid-frame: assert RST during data bit 3 -> OUT=1 and state IDLE next edge, no done. A new word 8'h3C sent afterwards frames correctly.
- Handshake: pulse TX_valid with 8'hFF while busy -> ignored, and only the original frame appears. Hold TX_valid high with two words -> second accepted on the done cycle, and the frames are separated by at least 1 CLK of idle-high.
